// File: rtl/ahb_lite_slave_mem.sv
// AHB-Lite single-slave memory: zero-wait word-organised RAM with byte/halfword lanes
// and a two-cycle ERROR response for illegal transfers.
module ahb_lite_slave_mem #(
    parameter int          MEM_DEPTH = 256,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic [31:0] HADDR,
    input  logic        HWRITE,
    input  logic [1:0]  HTRANS,
    input  logic [2:0]  HBURST,
    input  logic [2:0]  HSIZE,
    input  logic [31:0] HWDATA,
    output logic        HREADY,
    output logic [1:0]  HRESP,
    output logic [31:0] HRDATA
);

    localparam int          AW        = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam logic [31:0] MEM_BYTES = 32'(4 * MEM_DEPTH);

    typedef enum logic [1:0] {
        ST_OKAY,
        ST_ERR1,
        ST_ERR2
    } state_t;

    state_t state, state_next;

    logic [31:0]   mem [MEM_DEPTH];
    logic [31:0]   offset;
    logic          active, aligned, in_range, legal, illegal;
    logic [3:0]    strb;
    logic          dp_read, dp_write;
    logic [AW-1:0] dp_index;
    logic [3:0]    dp_strb;
    logic          unused_bits;

    assign unused_bits = ^{HBURST, HTRANS[0], offset};

    // Address-phase decode: legality and byte-lane strobes for the presented transfer.
    always_comb begin
        offset   = HADDR - BASE_ADDR;
        active   = HTRANS[1];
        in_range = (offset < MEM_BYTES);
        aligned  = 1'b0;
        strb     = 4'b0000;
        case (HSIZE)
            3'b000: begin
                aligned = 1'b1;
                strb    = 4'b0001 << HADDR[1:0];
            end
            3'b001: begin
                aligned = ~HADDR[0];
                strb    = HADDR[1] ? 4'b1100 : 4'b0011;
            end
            3'b010: begin
                aligned = (HADDR[1:0] == 2'b00);
                strb    = 4'b1111;
            end
            default: begin
                aligned = 1'b0;
                strb    = 4'b0000;
            end
        endcase
        legal   = active && aligned && in_range;
        illegal = active && !legal;
    end

    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            state <= ST_OKAY;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = ST_OKAY;
        case (state)
            ST_ERR1: state_next = ST_ERR2;
            default: state_next = illegal ? ST_ERR1 : ST_OKAY;
        endcase
    end

    always_comb begin
        HREADY = (state != ST_ERR1);
        HRESP  = (state == ST_OKAY) ? 2'b00 : 2'b01;
        HRDATA = (state == ST_OKAY && dp_read) ? mem[dp_index] : 32'h0;
    end

    // Address phase is only captured while the bus is not stalled by ERROR cycle 1.
    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            dp_read  <= 1'b0;
            dp_write <= 1'b0;
            dp_index <= '0;
            dp_strb  <= 4'b0000;
        end else if (HREADY) begin
            dp_read  <= legal && !HWRITE;
            dp_write <= legal && HWRITE;
            dp_index <= offset[AW+1:2];
            dp_strb  <= strb;
        end
    end

    always_ff @(posedge HCLK) begin
        if (HRESETn && dp_write) begin
            for (int i = 0; i < 4; i++) begin
                if (dp_strb[i]) begin
                    mem[dp_index][8*i +: 8] <= HWDATA[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_ahb_lite_slave_mem.sv
// Scoreboard bench for ahb_lite_slave_mem: beats are queued, expected data-phase
// responses are pushed when an address phase is issued and compared cycle by cycle.
module tb_ahb_lite_slave_mem;

    logic        HCLK;
    logic        HRESETn;
    logic [31:0] HADDR;
    logic        HWRITE;
    logic [1:0]  HTRANS;
    logic [2:0]  HBURST;
    logic [2:0]  HSIZE;
    logic [31:0] HWDATA;
    logic        HREADY;
    logic [1:0]  HRESP;
    logic [31:0] HRDATA;

    typedef struct {
        logic [1:0]  trans;
        logic        write;
        logic [31:0] addr;
        logic [2:0]  size;
        logic [2:0]  burst;
        logic [31:0] data;
    } beat_t;

    typedef struct {
        logic        ready;
        logic [1:0]  resp;
        logic [31:0] rdata;
        logic        has_wdata;
        logic [31:0] wdata;
    } exp_t;

    beat_t       stim[$];
    exp_t        sb[$];
    logic [31:0] model [256];
    int          tests    = 0;
    int          failures = 0;
    int          cycles   = 0;

    ahb_lite_slave_mem dut (
        .HCLK   (HCLK),
        .HRESETn(HRESETn),
        .HADDR  (HADDR),
        .HWRITE (HWRITE),
        .HTRANS (HTRANS),
        .HBURST (HBURST),
        .HSIZE  (HSIZE),
        .HWDATA (HWDATA),
        .HREADY (HREADY),
        .HRESP  (HRESP),
        .HRDATA (HRDATA)
    );

    initial begin
        HCLK = 1'b0;
        forever #5 HCLK = ~HCLK;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        tests++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s (cycle %0d): got %h, expected %h", tag, cycles, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [1:0] trans, input logic write, input logic [31:0] addr,
                                 input logic [2:0] size, input logic [2:0] burst, input logic [31:0] data);
        beat_t b;
        b.trans = trans;
        b.write = write;
        b.addr  = addr;
        b.size  = size;
        b.burst = burst;
        b.data  = data;
        stim.push_back(b);
    endtask

    function automatic exp_t mkExp(input logic ready, input logic [1:0] resp, input logic [31:0] rdata,
                                   input logic has_wdata, input logic [31:0] wdata);
        exp_t e;
        e.ready     = ready;
        e.resp      = resp;
        e.rdata     = rdata;
        e.has_wdata = has_wdata;
        e.wdata     = wdata;
        return e;
    endfunction

    // Reference behaviour for one sampled address phase.
    task automatic pushExpect(input beat_t b);
        logic       ok;
        logic [7:0] idx;
        idx = b.addr[9:2];
        if (b.trans < 2) begin
            sb.push_back(mkExp(1'b1, 2'b00, 32'h0, 1'b0, 32'h0));
            return;
        end
        case (b.size)
            3'd0:    ok = 1'b1;
            3'd1:    ok = (b.addr[0] == 1'b0);
            3'd2:    ok = (b.addr[1:0] == 2'b00);
            default: ok = 1'b0;
        endcase
        if (b.addr >= 32'd1024) ok = 1'b0;
        if (!ok) begin
            sb.push_back(mkExp(1'b0, 2'b01, 32'h0, 1'b0, 32'h0));
            sb.push_back(mkExp(1'b1, 2'b01, 32'h0, 1'b0, 32'h0));
        end else if (b.write) begin
            if (b.size == 3'd2) begin
                model[idx] = b.data;
            end else if (b.size == 3'd1) begin
                if (b.addr[1]) model[idx][31:16] = b.data[31:16];
                else           model[idx][15:0]  = b.data[15:0];
            end else begin
                case (b.addr[1:0])
                    2'd0: model[idx][7:0]   = b.data[7:0];
                    2'd1: model[idx][15:8]  = b.data[15:8];
                    2'd2: model[idx][23:16] = b.data[23:16];
                    2'd3: model[idx][31:24] = b.data[31:24];
                endcase
            end
            sb.push_back(mkExp(1'b1, 2'b00, 32'h0, 1'b1, b.data));
        end else begin
            sb.push_back(mkExp(1'b1, 2'b00, model[idx], 1'b0, 32'h0));
        end
    endtask

    task automatic stepCycle();
        exp_t  e;
        beat_t b;
        @(negedge HCLK);
        cycles++;
        if (sb.size() == 0) e = mkExp(1'b1, 2'b00, 32'h0, 1'b0, 32'h0);
        else                e = sb.pop_front();
        checkOutput("hready", {31'b0, HREADY}, {31'b0, e.ready});
        checkOutput("hresp",  {30'b0, HRESP},  {30'b0, e.resp});
        checkOutput("hrdata", HRDATA, e.rdata);
        HWDATA = e.has_wdata ? e.wdata : $urandom();
        if (e.ready) begin
            if (stim.size() > 0) begin
                b = stim.pop_front();
            end else begin
                b.trans = 2'b00;
                b.write = 1'($urandom_range(0, 1));
                b.addr  = $urandom();
                b.size  = 3'($urandom_range(0, 7));
                b.burst = 3'b000;
                b.data  = 32'h0;
            end
            HTRANS = b.trans;
            HWRITE = b.write;
            HADDR  = b.addr;
            HSIZE  = b.size;
            HBURST = b.burst;
            pushExpect(b);
        end
    endtask

    task automatic drain();
        int guard = 0;
        while ((stim.size() > 0 || sb.size() > 1) && guard < 500) begin
            stepCycle();
            guard++;
        end
        if (guard >= 500) begin
            failures++;
            $display("[TB] FAIL drain: pipeline did not empty, %0d beats left", stim.size());
        end
        repeat (2) stepCycle();
    endtask

    task automatic doReset(input int n);
        @(negedge HCLK);
        HRESETn = 1'b0;
        for (int i = 0; i < n; i++) begin
            HADDR  = $urandom();
            HWRITE = 1'($urandom_range(0, 1));
            HTRANS = 2'($urandom_range(0, 3));
            HSIZE  = 3'($urandom_range(0, 7));
            HBURST = 3'($urandom_range(0, 7));
            HWDATA = $urandom();
            @(posedge HCLK);
            @(negedge HCLK);
            cycles++;
            checkOutput("rst_hready", {31'b0, HREADY}, 32'h1);
            checkOutput("rst_hresp",  {30'b0, HRESP},  32'h0);
            checkOutput("rst_hrdata", HRDATA, 32'h0);
        end
        HRESETn = 1'b1;
        HTRANS  = 2'b00;
        sb.delete();
        sb.push_back(mkExp(1'b1, 2'b00, 32'h0, 1'b0, 32'h0));
    endtask

    initial begin
        logic [31:0] saved;
        HRESETn = 1'b0;
        HADDR   = 32'h0;
        HWRITE  = 1'b0;
        HTRANS  = 2'b00;
        HBURST  = 3'b000;
        HSIZE   = 3'b010;
        HWDATA  = 32'h0;

        doReset(2);
        repeat (3) stepCycle();

        // word write then read of the same word, plus a byte read returning the full word
        applyStimulus(2'b10, 1'b1, 32'h10, 3'd2, 3'd0, 32'hDEADBEEF);
        applyStimulus(2'b10, 1'b0, 32'h10, 3'd2, 3'd0, 32'h0);
        applyStimulus(2'b10, 1'b0, 32'h13, 3'd0, 3'd0, 32'h0);
        drain();

        // byte and halfword lanes
        applyStimulus(2'b10, 1'b1, 32'h20, 3'd2, 3'd0, 32'h00000000);
        applyStimulus(2'b10, 1'b1, 32'h21, 3'd0, 3'd0, 32'h0000AB00);
        applyStimulus(2'b10, 1'b1, 32'h22, 3'd1, 3'd0, 32'h12340000);
        applyStimulus(2'b10, 1'b0, 32'h20, 3'd2, 3'd0, 32'h0);
        drain();

        // INCR4 write then read bursts with no gaps, then a read burst containing BUSY
        for (int i = 0; i < 4; i++)
            applyStimulus((i == 0) ? 2'b10 : 2'b11, 1'b1, 32'h40 + 4*i, 3'd2, 3'd3, i + 1);
        for (int i = 0; i < 4; i++)
            applyStimulus((i == 0) ? 2'b10 : 2'b11, 1'b0, 32'h40 + 4*i, 3'd2, 3'd3, 32'h0);
        applyStimulus(2'b10, 1'b0, 32'h40, 3'd2, 3'd1, 32'h0);
        applyStimulus(2'b01, 1'b0, 32'h44, 3'd2, 3'd1, 32'h0);
        applyStimulus(2'b11, 1'b0, 32'h44, 3'd2, 3'd1, 32'h0);
        drain();

        // illegal transfers, then readback of the words they targeted
        applyStimulus(2'b10, 1'b1, 32'h00,  3'd2, 3'd0, 32'h11111111);
        applyStimulus(2'b10, 1'b1, 32'h50,  3'd2, 3'd0, 32'hA5A5A5A5);
        applyStimulus(2'b10, 1'b1, 32'h3FC, 3'd2, 3'd0, 32'hCAFEF00D);
        applyStimulus(2'b10, 1'b0, 32'h02,  3'd2, 3'd0, 32'h0);
        applyStimulus(2'b10, 1'b1, 32'h400, 3'd2, 3'd0, 32'h00000BAD);
        applyStimulus(2'b10, 1'b1, 32'h50,  3'd3, 3'd0, 32'hFFFFFFFF);
        applyStimulus(2'b10, 1'b1, 32'h01,  3'd1, 3'd0, 32'hFFFFFFFF);
        applyStimulus(2'b10, 1'b0, 32'h00,  3'd2, 3'd0, 32'h0);
        applyStimulus(2'b10, 1'b0, 32'h50,  3'd2, 3'd0, 32'h0);
        applyStimulus(2'b10, 1'b0, 32'h3FC, 3'd2, 3'd0, 32'h0);
        drain();

        // error in the middle of a burst; remaining beats proceed
        applyStimulus(2'b10, 1'b1, 32'h60, 3'd2, 3'd3, 32'h7);
        applyStimulus(2'b11, 1'b1, 32'h66, 3'd2, 3'd3, 32'h8);
        applyStimulus(2'b11, 1'b1, 32'h68, 3'd2, 3'd3, 32'h9);
        applyStimulus(2'b11, 1'b0, 32'h60, 3'd2, 3'd3, 32'h0);
        applyStimulus(2'b11, 1'b0, 32'h64, 3'd1, 3'd3, 32'h0);
        applyStimulus(2'b10, 1'b0, 32'h68, 3'd2, 3'd0, 32'h0);
        drain();

        // reset asserted during the data phase of a write must drop it
        applyStimulus(2'b10, 1'b1, 32'h30, 3'd2, 3'd0, 32'h5);
        drain();
        applyStimulus(2'b10, 1'b1, 32'h30, 3'd2, 3'd0, 32'h77);
        saved = model[12];
        stepCycle();
        doReset(1);
        model[12] = saved;
        applyStimulus(2'b10, 1'b0, 32'h30, 3'd2, 3'd0, 32'h0);
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
